// File: rtl/instr_pack_loader_if.sv
// Host field stream and instruction-memory write port of the program loader.
// master = host/memory side, slave = the loader.
interface instr_pack_loader_if #(
  parameter int unsigned ADDR_W = 8
) ();
  logic              in_valid;
  logic              in_ready;
  logic [4:0]        in_op;
  logic [2:0]        in_rs;
  logic [2:0]        in_rt;
  logic [2:0]        in_rd;
  logic [1:0]        in_fn;
  logic [15:0]       in_imm;
  logic              in_last;
  logic              mem_wr_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [15:0]       mem_data;
  logic              mem_ready;

  modport master (
    output in_valid, in_op, in_rs, in_rt, in_rd, in_fn, in_imm, in_last, mem_ready,
    input  in_ready, mem_wr_en, mem_addr, mem_data
  );

  modport slave (
    input  in_valid, in_op, in_rs, in_rt, in_rd, in_fn, in_imm, in_last, mem_ready,
    output in_ready, mem_wr_en, mem_addr, mem_data
  );
endinterface

// File: rtl/instr_pack_loader.sv
// Packs decoded instruction fields into 16-bit words, range-checks immediates,
// and writes accepted words to sequential instruction-memory addresses.
module instr_pack_loader #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DEPTH  = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  instr_pack_loader_if.slave bus,
  output logic              done,
  output logic              err,
  output logic [ADDR_W-1:0] err_addr,
  output logic [ADDR_W:0]   word_cnt
);

  localparam int unsigned CNT_W = ADDR_W + 1;
  localparam int unsigned CMP_W = ADDR_W + 2;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic              pend_q, pend_d;
  logic              last_q, last_d;
  logic [15:0]       data_q, data_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              err_q, err_d;
  logic [ADDR_W-1:0] err_addr_q, err_addr_d;
  logic              done_q, done_d;

  logic [15:0]       pack_word;
  logic              pack_ok;
  logic              in_ready_c;
  logic              accept_c;
  logic              wr_fire_c;
  logic              finish_c;

  // Instruction format and immediate range by opcode.
  always_comb begin
    pack_word = {bus.in_op, bus.in_rs, bus.in_rt, bus.in_rd, bus.in_fn};
    pack_ok   = 1'b1;
    casez (bus.in_op)
      5'b01000, 5'b01001, 5'b10000, 5'b10001, 5'b10011: begin
        pack_word = {bus.in_op, bus.in_rs, bus.in_rd, bus.in_imm[4:0]};
        pack_ok   = (&bus.in_imm[15:4]) | ~(|bus.in_imm[15:4]);
      end
      5'b01010, 5'b01011: begin
        pack_word = {bus.in_op, bus.in_rs, bus.in_rd, bus.in_imm[4:0]};
        pack_ok   = ~(|bus.in_imm[15:5]);
      end
      5'b011??, 5'b00101, 5'b00111, 5'b11000: begin
        pack_word = {bus.in_op, bus.in_rs, bus.in_imm[7:0]};
        pack_ok   = (&bus.in_imm[15:7]) | ~(|bus.in_imm[15:7]);
      end
      5'b10010: begin
        pack_word = {bus.in_op, bus.in_rs, bus.in_imm[7:0]};
        pack_ok   = ~(|bus.in_imm[15:8]);
      end
      5'b00100, 5'b00110: begin
        pack_word = {bus.in_op, bus.in_imm[10:0]};
        pack_ok   = (&bus.in_imm[15:10]) | ~(|bus.in_imm[15:10]);
      end
      default: begin
        pack_word = {bus.in_op, bus.in_rs, bus.in_rt, bus.in_rd, bus.in_fn};
        pack_ok   = 1'b1;
      end
    endcase
  end

  // Ready only while loading, with the output slot free or draining, and capacity left.
  assign in_ready_c = (state_q == S_LOAD) && (!pend_q || bus.mem_ready) &&
                      ((CMP_W'(cnt_q) + CMP_W'(pend_q)) < CMP_W'(DEPTH));
  assign accept_c   = bus.in_valid && in_ready_c && !start;
  assign wr_fire_c  = pend_q && bus.mem_ready;

  always_comb begin
    state_d    = state_q;
    pend_d     = pend_q;
    last_d     = last_q;
    data_d     = data_q;
    addr_d     = addr_q;
    cnt_d      = cnt_q;
    err_d      = err_q;
    err_addr_d = err_addr_q;
    done_d     = done_q;
    finish_c   = 1'b0;

    if (start) begin
      state_d    = S_LOAD;
      pend_d     = 1'b0;
      last_d     = 1'b0;
      addr_d     = '0;
      cnt_d      = '0;
      err_d      = 1'b0;
      err_addr_d = '0;
      done_d     = 1'b0;
    end else if (state_q == S_LOAD) begin
      if (wr_fire_c) begin
        pend_d = 1'b0;
        cnt_d  = cnt_q + CNT_W'(1);
        // Address holds at the last slot once capacity is reached.
        if (cnt_d == CNT_W'(DEPTH)) begin
          finish_c = 1'b1;
        end else begin
          addr_d = addr_q + ADDR_W'(1);
        end
        if (last_q) begin
          finish_c = 1'b1;
        end
      end
      if (accept_c) begin
        if (pack_ok) begin
          pend_d = 1'b1;
          last_d = bus.in_last;
          data_d = pack_word;
        end else begin
          err_d = 1'b1;
          if (!err_q) begin
            err_addr_d = addr_d;
          end
          if (bus.in_last) begin
            finish_c = 1'b1;
          end
        end
      end
      if (finish_c) begin
        state_d = S_DONE;
        done_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      pend_q     <= 1'b0;
      last_q     <= 1'b0;
      data_q     <= '0;
      addr_q     <= '0;
      cnt_q      <= '0;
      err_q      <= 1'b0;
      err_addr_q <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      pend_q     <= pend_d;
      last_q     <= last_d;
      data_q     <= data_d;
      addr_q     <= addr_d;
      cnt_q      <= cnt_d;
      err_q      <= err_d;
      err_addr_q <= err_addr_d;
      done_q     <= done_d;
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.mem_wr_en = pend_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_data  = data_q;
  assign done          = done_q;
  assign err           = err_q;
  assign err_addr      = err_addr_q;
  assign word_cnt      = cnt_q;

endmodule

// File: tb/tb_instr_pack_loader.sv
// Directed bench for instr_pack_loader: packing/range vector table plus
// hand-written stall, depth-limit, restart and reset sequences.
module tb_instr_pack_loader;

  logic clk;
  logic rst;
  logic start_a, start_b;
  logic done_a, done_b, err_a, err_b;
  logic [7:0] err_addr_a, err_addr_b;
  logic [8:0] word_cnt_a, word_cnt_b;

  instr_pack_loader_if #(.ADDR_W(8)) if_a ();
  instr_pack_loader_if #(.ADDR_W(8)) if_b ();

  instr_pack_loader #(.ADDR_W(8), .DEPTH(256)) u_dut (
    .clk(clk), .rst(rst), .start(start_a), .bus(if_a),
    .done(done_a), .err(err_a), .err_addr(err_addr_a), .word_cnt(word_cnt_a)
  );

  instr_pack_loader #(.ADDR_W(8), .DEPTH(4)) u_small (
    .clk(clk), .rst(rst), .start(start_b), .bus(if_b),
    .done(done_b), .err(err_b), .err_addr(err_addr_b), .word_cnt(word_cnt_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  op;
    logic [2:0]  rs;
    logic [2:0]  rt;
    logic [2:0]  rd;
    logic [1:0]  fn;
    logic [15:0] imm;
    logic        ok;
    logic [15:0] word;
  } vec_t;

  vec_t vecs[16];
  int   n_cmp;
  int   n_err;
  int   acc;
  int   wr;
  bit   fire;
  bit   wfire;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic set_a(input logic [4:0] op, input logic [2:0] rs, input logic [2:0] rt,
                       input logic [2:0] rd, input logic [1:0] fn, input logic [15:0] imm,
                       input logic last);
    if_a.in_op   = op;
    if_a.in_rs   = rs;
    if_a.in_rt   = rt;
    if_a.in_rd   = rd;
    if_a.in_fn   = fn;
    if_a.in_imm  = imm;
    if_a.in_last = last;
    if_a.in_valid = 1'b1;
  endtask

  // Called at a falling edge; returns at the falling edge after the accepting edge.
  task automatic push(input logic [4:0] op, input logic [2:0] rs, input logic [2:0] rt,
                      input logic [2:0] rd, input logic [1:0] fn, input logic [15:0] imm,
                      input logic last);
    set_a(op, rs, rt, rd, fn, imm, last);
    for (int i = 0; i < 20; i++) begin
      #1;
      if (if_a.in_ready) begin
        @(negedge clk);
        if_a.in_valid = 1'b0;
        return;
      end
      @(negedge clk);
    end
    if_a.in_valid = 1'b0;
    n_cmp++;
    n_err++;
    $display("FAIL push_timeout: got no accept, expected accept within 20 cycles");
  endtask

  task automatic do_start();
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
  endtask

  task automatic mk(input int i, input logic [4:0] op, input logic [2:0] rs, input logic [2:0] rt,
                    input logic [2:0] rd, input logic [1:0] fn, input logic [15:0] imm,
                    input logic ok, input logic [15:0] word);
    vecs[i].op = op; vecs[i].rs = rs; vecs[i].rt = rt; vecs[i].rd = rd;
    vecs[i].fn = fn; vecs[i].imm = imm; vecs[i].ok = ok; vecs[i].word = word;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst = 1'b1;
    start_a = 1'b0;
    start_b = 1'b0;
    if_a.in_valid = 1'b0; if_a.in_op = '0; if_a.in_rs = '0; if_a.in_rt = '0; if_a.in_rd = '0;
    if_a.in_fn = '0; if_a.in_imm = '0; if_a.in_last = 1'b0; if_a.mem_ready = 1'b1;
    if_b.in_valid = 1'b0; if_b.in_op = '0; if_b.in_rs = '0; if_b.in_rt = '0; if_b.in_rd = '0;
    if_b.in_fn = '0; if_b.in_imm = '0; if_b.in_last = 1'b0; if_b.mem_ready = 1'b1;

    //   idx op        rs    rt    rd    fn     imm       ok    word
    mk( 0, 5'b01000, 3'd1, 3'd7, 3'd2, 2'd0, 16'hFFFD, 1'b1, 16'h415D); // ADDI -3
    mk( 1, 5'b01000, 3'd1, 3'd0, 3'd2, 2'd0, 16'h000F, 1'b1, 16'h414F); // ADDI 15
    mk( 2, 5'b01000, 3'd1, 3'd0, 3'd2, 2'd0, 16'h0010, 1'b0, 16'h0000); // ADDI 16
    mk( 3, 5'b01001, 3'd3, 3'd0, 3'd4, 2'd0, 16'hFFF0, 1'b1, 16'h4B90); // SUBI -16
    mk( 4, 5'b01001, 3'd3, 3'd0, 3'd4, 2'd0, 16'hFFEF, 1'b0, 16'h0000); // SUBI -17
    mk( 5, 5'b01010, 3'd0, 3'd0, 3'd0, 2'd0, 16'h001F, 1'b1, 16'h501F); // XORI 31
    mk( 6, 5'b01010, 3'd0, 3'd0, 3'd0, 2'd0, 16'hFFFF, 1'b0, 16'h0000); // XORI -1
    mk( 7, 5'b01101, 3'd5, 3'd0, 3'd0, 2'd0, 16'hFF80, 1'b1, 16'h6D80); // branch -128
    mk( 8, 5'b11000, 3'd2, 3'd0, 3'd0, 2'd0, 16'h0080, 1'b0, 16'h0000); // LBI 128
    mk( 9, 5'b10010, 3'd7, 3'd5, 3'd0, 2'd0, 16'h00FF, 1'b1, 16'h97FF); // SLBI 255
    mk(10, 5'b10010, 3'd7, 3'd0, 3'd0, 2'd0, 16'h0100, 1'b0, 16'h0000); // SLBI 256
    mk(11, 5'b00110, 3'd0, 3'd0, 3'd0, 2'd0, 16'hFC00, 1'b1, 16'h3400); // JAL -1024
    mk(12, 5'b00100, 3'd0, 3'd0, 3'd0, 2'd0, 16'h0400, 1'b0, 16'h0000); // J 1024
    mk(13, 5'b00000, 3'd1, 3'd2, 3'd3, 2'd2, 16'h7FFF, 1'b1, 16'h014E); // R-format
    mk(14, 5'b10000, 3'd6, 3'd0, 3'd1, 2'd0, 16'h0000, 1'b1, 16'h8620); // ST 0
    mk(15, 5'b00101, 3'd4, 3'd0, 3'd0, 2'd0, 16'h007F, 1'b1, 16'h2C7F); // JR 127

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_in_ready_a", 32'(if_a.in_ready), 32'd0);
    chk("rst_wr_en_a", 32'(if_a.mem_wr_en), 32'd0);
    chk("rst_addr_a", 32'(if_a.mem_addr), 32'd0);
    chk("rst_data_a", 32'(if_a.mem_data), 32'd0);
    chk("rst_done_a", 32'(done_a), 32'd0);
    chk("rst_err_a", 32'(err_a), 32'd0);
    chk("rst_err_addr_a", 32'(err_addr_a), 32'd0);
    chk("rst_cnt_a", 32'(word_cnt_a), 32'd0);
    chk("rst_in_ready_b", 32'(if_b.in_ready), 32'd0);
    chk("rst_done_b", 32'(done_b), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_in_ready_a", 32'(if_a.in_ready), 32'd0);

    // Packing and range vectors, one single-bundle session each
    if_a.mem_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      do_start();
      push(vecs[i].op, vecs[i].rs, vecs[i].rt, vecs[i].rd, vecs[i].fn, vecs[i].imm, 1'b1);
      chk($sformatf("v%0d_wr_en", i), 32'(if_a.mem_wr_en), 32'(vecs[i].ok));
      chk($sformatf("v%0d_err", i), 32'(err_a), 32'(!vecs[i].ok));
      if (vecs[i].ok) begin
        chk($sformatf("v%0d_data", i), 32'(if_a.mem_data), 32'(vecs[i].word));
        chk($sformatf("v%0d_addr", i), 32'(if_a.mem_addr), 32'd0);
        chk($sformatf("v%0d_done_early", i), 32'(done_a), 32'd0);
        @(negedge clk);
        chk($sformatf("v%0d_cnt", i), 32'(word_cnt_a), 32'd1);
      end else begin
        chk($sformatf("v%0d_err_addr", i), 32'(err_addr_a), 32'd0);
        chk($sformatf("v%0d_cnt", i), 32'(word_cnt_a), 32'd0);
      end
      chk($sformatf("v%0d_done", i), 32'(done_a), 32'd1);
    end

    // J 1023 then out-of-range XORI with in_last
    do_start();
    push(5'b00100, 3'd0, 3'd0, 3'd0, 2'd0, 16'd1023, 1'b0);
    chk("j_wr_en", 32'(if_a.mem_wr_en), 32'd1);
    chk("j_data", 32'(if_a.mem_data), 32'h23FF);
    chk("j_addr", 32'(if_a.mem_addr), 32'd0);
    push(5'b01010, 3'd0, 3'd0, 3'd0, 2'd0, 16'd32, 1'b1);
    chk("xori_err", 32'(err_a), 32'd1);
    chk("xori_err_addr", 32'(err_addr_a), 32'd1);
    chk("xori_cnt", 32'(word_cnt_a), 32'd1);
    chk("xori_done", 32'(done_a), 32'd1);
    chk("xori_no_write", 32'(if_a.mem_wr_en), 32'd0);

    // Back-pressure: two stalled cycles after the first word
    do_start();
    if_a.mem_ready = 1'b0;
    set_a(5'b00000, 3'd1, 3'd2, 3'd3, 2'd1, 16'h0, 1'b0);
    #1 chk("stall_rdy0", 32'(if_a.in_ready), 32'd1);
    @(negedge clk);
    chk("stall_w0_en", 32'(if_a.mem_wr_en), 32'd1);
    chk("stall_w0_data", 32'(if_a.mem_data), 32'h014D);
    set_a(5'b00001, 3'd2, 3'd3, 3'd4, 2'd2, 16'h0, 1'b0);
    #1 chk("stall_rdy1", 32'(if_a.in_ready), 32'd0);
    @(negedge clk);
    chk("stall_hold_data", 32'(if_a.mem_data), 32'h014D);
    chk("stall_hold_addr", 32'(if_a.mem_addr), 32'd0);
    chk("stall_hold_cnt", 32'(word_cnt_a), 32'd0);
    #1 chk("stall_rdy2", 32'(if_a.in_ready), 32'd0);
    @(negedge clk);
    chk("stall_hold_data2", 32'(if_a.mem_data), 32'h014D);
    if_a.mem_ready = 1'b1;
    #1 chk("stall_rdy3", 32'(if_a.in_ready), 32'd1);
    @(negedge clk);
    chk("stall_w1_addr", 32'(if_a.mem_addr), 32'd1);
    chk("stall_w1_data", 32'(if_a.mem_data), 32'h0A72);
    chk("stall_w1_cnt", 32'(word_cnt_a), 32'd1);
    set_a(5'b11111, 3'd7, 3'd7, 3'd7, 2'd3, 16'h0, 1'b1);
    @(negedge clk);
    if_a.in_valid = 1'b0;
    chk("stall_w2_addr", 32'(if_a.mem_addr), 32'd2);
    chk("stall_w2_data", 32'(if_a.mem_data), 32'hFFFF);
    chk("stall_w2_cnt", 32'(word_cnt_a), 32'd2);
    @(negedge clk);
    chk("stall_end_wr_en", 32'(if_a.mem_wr_en), 32'd0);
    chk("stall_end_cnt", 32'(word_cnt_a), 32'd3);
    chk("stall_end_done", 32'(done_a), 32'd1);

    // Capacity limit on the DEPTH=4 instance
    start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
    acc = 0;
    wr = 0;
    if_b.in_op = 5'b00000; if_b.in_rs = 3'd1; if_b.in_rt = 3'd1; if_b.in_rd = 3'd1;
    if_b.in_valid = 1'b1;
    repeat (16) begin
      #1;
      fire  = if_b.in_valid && if_b.in_ready;
      wfire = if_b.mem_wr_en && if_b.mem_ready;
      @(negedge clk);
      if (fire) acc++;
      if (wfire) wr++;
      if_b.in_valid = (acc < 6);
    end
    if_b.in_valid = 1'b1;
    chk("depth_accepted", 32'(acc), 32'd4);
    chk("depth_written", 32'(wr), 32'd4);
    chk("depth_cnt", 32'(word_cnt_b), 32'd4);
    chk("depth_done", 32'(done_b), 32'd1);
    #1 chk("depth_in_ready", 32'(if_b.in_ready), 32'd0);
    @(negedge clk);
    if_b.in_valid = 1'b0;

    // start during a session, coinciding with a valid bundle
    do_start();
    push(5'b01000, 3'd0, 3'd0, 3'd0, 2'd0, 16'd100, 1'b0);
    chk("restart_pre_err", 32'(err_a), 32'd1);
    push(5'b01000, 3'd1, 3'd0, 3'd2, 2'd0, 16'hFFFD, 1'b0);
    start_a = 1'b1;
    set_a(5'b00000, 3'd1, 3'd2, 3'd3, 2'd2, 16'h0, 1'b0);
    @(negedge clk);
    start_a = 1'b0;
    if_a.in_valid = 1'b0;
    chk("restart_err", 32'(err_a), 32'd0);
    chk("restart_wr_en", 32'(if_a.mem_wr_en), 32'd0);
    chk("restart_cnt", 32'(word_cnt_a), 32'd0);
    chk("restart_done", 32'(done_a), 32'd0);
    push(5'b00101, 3'd4, 3'd0, 3'd0, 2'd0, 16'h007F, 1'b1);
    chk("restart_addr", 32'(if_a.mem_addr), 32'd0);
    chk("restart_data", 32'(if_a.mem_data), 32'h2C7F);
    @(negedge clk);

    // Reset while a write is pending
    do_start();
    push(5'b01010, 3'd0, 3'd0, 3'd0, 2'd0, 16'd40, 1'b0);
    if_a.mem_ready = 1'b0;
    push(5'b01000, 3'd1, 3'd0, 3'd2, 2'd0, 16'h0005, 1'b0);
    chk("rstp_pending", 32'(if_a.mem_wr_en), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("rstp_wr_en", 32'(if_a.mem_wr_en), 32'd0);
    chk("rstp_data", 32'(if_a.mem_data), 32'd0);
    chk("rstp_err", 32'(err_a), 32'd0);
    chk("rstp_cnt", 32'(word_cnt_a), 32'd0);
    rst = 1'b0;
    if_a.mem_ready = 1'b1;
    @(negedge clk);
    chk("rstp_no_write", 32'(if_a.mem_wr_en), 32'd0);
    chk("rstp_in_ready", 32'(if_a.in_ready), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/instr_pack_loader.md
# instr_pack_loader

Loads an assembled program into instruction memory for the demo bench. Accepts decoded instruction fields over a valid/ready stream, packs them into 16-bit instruction words and range-checks each immediate against the extension rule that the immediate extender applies when decoding. Writes accepted words to sequential instruction-memory addresses. Sits between the bench/host command stream and the instruction-memory write port.

## Interface
- ADDR_W, 8: instruction-memory address width.
- DEPTH, 256: number of loadable words; must be ≤ 2^ADDR_W.
- clk  in  1  single clock; all state changes on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; begins a new load session at address 0.
- in_valid  in  1  field bundle valid.
- in_ready  out  1  block can accept a bundle this cycle.
- in_op  in  5  opcode, becomes word[15:11].
- in_rs, in_rt, in_rd  in  3 each  register fields.
- in_fn  in  2  R-format function field.
- in_imm  in  16  two's-complement immediate.
- in_last  in  1  marks final bundle of the program.
- mem_wr_en  out  1  write strobe, one cycle per word.
- mem_addr  out  ADDR_W  write address.
- mem_data  out  16  packed instruction word.
- mem_ready  in  1  memory accepts the write this cycle.
- done  out  1  session finished (last word written or DEPTH reached).
- err  out  1  sticky: at least one immediate was out of range.
- err_addr  out  ADDR_W  address of the first rejected bundle.
- word_cnt  out  ADDR_W+1  words written this session.

## Operation
- Packing by in_op:
  - ADDI 01000, SUBI 01001, ST 10000, LD 10001, STU 10011: {op, rs, rd, imm[4:0]}; signed range −16..15.
  - XORI 01010, ANDNI 01011: {op, rs, rd, imm[4:0]}; unsigned range 0..31.
  - Branches 011xx, JR 00101, JALR 00111, LBI 11000: {op, rs, imm[7:0]}; signed range −128..127.
  - SLBI 10010: {op, rs, imm[7:0]}; unsigned range 0..255.
  - J 00100, JAL 00110: {op, imm[10:0]}; signed range −1024..1023.
  - All other opcodes: {op, rs, rt, rd, fn}; in_imm ignored, no check.
- Out-of-range bundle: consumed (handshake completes), nothing written, address not advanced; err set; err_addr captures the current address only on the first error of a session.
- FSM: IDLE → LOAD on start; LOAD → DONE when the in_last word is written, when a rejected bundle carries in_last, or when word_cnt reaches DEPTH; DONE → LOAD on start. start in LOAD restarts the session.
- start clears the address, word_cnt, err, err_addr and done, and drops any pending unwritten word.

## Timing
- Reset: state IDLE; in_ready, mem_wr_en, done, err = 0; mem_addr, mem_data, err_addr, word_cnt = 0.
- in_ready = (state == LOAD) && (no pending word || mem_ready) && (word_cnt + pending < DEPTH).
- A bundle accepted in cycle N appears as mem_wr_en = 1 with its packed word in cycle N+1. mem_wr_en, mem_addr and mem_data are held stable until mem_ready = 1.
- The write completes on a cycle with mem_wr_en && mem_ready. In that cycle's edge, the address and word_cnt increment. If a new bundle is also accepted in that cycle, it is presented in the next cycle, giving one word per cycle at full throughput.
- done rises in the cycle after the terminating write (or the terminating rejection) completes. done holds until start or rst.
- start coinciding with an input handshake: start wins and the bundle is discarded.
- rst mid-session aborts immediately. Any pending write is not issued.
- The address does not wrap. Reaching DEPTH forces DONE, and in_ready stays 0.

## Test plan
- ADDI rs=1 rd=2 imm=−3, mem_ready=1 → cycle after accept: mem_wr_en=1, addr 0, data 0x415D.
- J imm=1023, then XORI rs=0 rd=0 imm=32 with in_last → word 0x23FF at addr 0. XORI rejected: err=1, err_addr=1, word_cnt=1, done=1.
- 3 back-to-back R-format bundles, mem_ready held 0 for 2 cycles after the first → in_ready=0 while stalled, data stable, final addrs 0,1,2, no loss or duplication.
- DEPTH=4, 6 bundles offered → 4 written, in_ready=0 thereafter, done=1, word_cnt=4.
- start asserted mid-session together with a valid bundle → bundle dropped, next word written at addr 0, err cleared.
- rst while a write is pending → next cycle all outputs at reset values, no write issued.
